// File: rtl/btn_pkg.sv
// btn_pkg: shared types and default constants for the push-button step generator.
// Holds the 2-bit FSM state encoding and the default debounce / auto-repeat timings.
package btn_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_e;

  // Default timings, in clk cycles.
  localparam int unsigned BTN_DEBOUNCE_CYCLES_DEF = 20000;
  localparam int unsigned BTN_REPEAT_DELAY_DEF    = 5000000;
  localparam int unsigned BTN_REPEAT_PERIOD_DEF   = 2000000;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned btn_cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous level; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_step_gen.sv
// button_step_gen: debounces a bouncing push-button and emits one registered step
// pulse per accepted press. Optional auto-repeat while held is compiled in with
// the BTN_AUTOREPEAT_EN macro; without it the REPEAT_* parameters have no effect.
module button_step_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic en,
  output logic step,
  output logic pressed
);

  localparam int unsigned CNT_W = btn_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync;
  btn_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            step_q;
  logic            pressed_q;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_raw),
    .q    (sync)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = btn_cnt_width(REP_MAX);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_phase_q;  // 0: waiting out the first delay, 1: periodic repeats
  logic             rep_fire;

  assign rep_fire = rep_phase_q ? (rep_cnt_q == REP_PER_LAST) : (rep_cnt_q == REP_DLY_LAST);
`else
  // Zero repeat timings would be meaningless even though they are unused here.
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat_cfg
  end
`endif

  // Debounce FSM with registered step/pressed outputs and optional repeat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      pressed_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      step_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sync) begin
            state_q <= ST_DB_PRESS;
            cnt_q   <= '0;
          end
        end
        ST_DB_PRESS: begin
          if (!sync) begin
            // Glitch: drop back without a step.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_HELD;
            cnt_q     <= '0;
            pressed_q <= 1'b1;
            step_q    <= en;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!sync) begin
            state_q <= ST_DB_RELEASE;
            cnt_q   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rep_fire) begin
            step_q      <= en & ~step_q;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + REP_W'(1);
          end
`endif
        end
        ST_DB_RELEASE: begin
          if (sync) begin
            // Release bounce: back to HELD, repeat count is kept as is.
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign step    = step_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_button_step_gen.sv
// tb_button_step_gen: directed, table-driven check of button_step_gen with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5. Works with or without
// BTN_AUTOREPEAT_EN defined; expected repeat steps are added when it is.
module tb_button_step_gen;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic en;
  logic step;
  logic pressed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_step_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .en     (en),
    .step   (step),
    .pressed(pressed)
  );

  typedef struct {
    logic btn;
    logic en;
    logic exp_step;
    logic exp_pressed;
    int   scen;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean press held for h edges, then released for tail edges.
  // Edge g=1 is the first edge that samples the new level. A press is accepted
  // when h >= DB+1 (the synchronizer stretches it by two edges), the step lands
  // after edge DB+3, pressed drops DB+3 edges after the release is sampled.
  // Repeat steps follow at DB+3+RD, then every RP while the FSM still sees high.
  function automatic void add_press(input int scen, input int h, input logic en_v, input int tail);
    for (int g = 1; g <= h + tail; g++) begin
      vec_t v;
      logic st;
      st = 1'b0;
      if (h >= DB + 1) begin
        if (g == DB + 3) st = 1'b1;
        if (REP_ON && g >= DB + 3 + RD && g <= h + 2 && ((g - DB - 3 - RD) % RP) == 0) st = 1'b1;
      end
      v.btn         = (g <= h);
      v.en          = en_v;
      v.exp_step    = st & en_v;
      v.exp_pressed = (h >= DB + 1) && (g >= DB + 3) && (g < h + DB + 3);
      v.scen        = scen;
      vecs.push_back(v);
    end
  endfunction

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    en      = 1'b1;

    // Table: long press, en=0 press, short boundary presses, 38-cycle hold.
    add_press(0, 50, 1'b1, 10);
    add_press(1, 8,  1'b0, 9);
    add_press(2, 4,  1'b1, 8);
    add_press(3, 5,  1'b1, 8);
    add_press(4, 38, 1'b1, 10);
    add_press(5, 38, 1'b0, 10);

    tick();
    check("reset.step", step, 1'b0);
    check("reset.pressed", pressed, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle.step", step, 1'b0);
    check("idle.pressed", pressed, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      btn_raw = vecs[i].btn;
      en      = vecs[i].en;
      tick();
      check($sformatf("vec%0d.s%0d.step", i, vecs[i].scen), step, vecs[i].exp_step);
      check($sformatf("vec%0d.s%0d.pressed", i, vecs[i].scen), pressed, vecs[i].exp_pressed);
      if (i == vecs.size() - 1 || vecs[i+1].scen != vecs[i].scen)
        $display("[TB] scenario %0d done, %0d checks so far, %0d failed", vecs[i].scen, n_tests, n_fail);
    end

    // Bounce 1,0,1,1,0 then steady high from edge 6 to edge 20, release after.
    en = 1'b1;
    for (int g = 1; g <= 30; g++) begin
      logic [4:0] bpat;
      bpat = 5'b01101;  // bit k-1 is the level sampled at edge k
      btn_raw = (g <= 5) ? bpat[g-1] : (g <= 20);
      tick();
      check($sformatf("bounce.g%0d.step", g), step, (g == 12) || (REP_ON && g == 22));
      check($sformatf("bounce.g%0d.pressed", g), pressed, (g >= 12 && g <= 26));
    end
    $display("[TB] bounce sequence done, %0d checks so far, %0d failed", n_tests, n_fail);

    // Release bounce: high 1..10, low 11..12, high 13..20, low afterwards.
    for (int g = 1; g <= 30; g++) begin
      btn_raw = (g <= 10) || (g >= 13 && g <= 20);
      tick();
      check($sformatf("relbounce.g%0d.step", g), step, (g == 7) || (REP_ON && g == 20));
      check($sformatf("relbounce.g%0d.pressed", g), pressed, (g >= 7 && g <= 26));
    end
    $display("[TB] release-bounce sequence done, %0d checks so far, %0d failed", n_tests, n_fail);

    // Reset during DB_PRESS with the button held.
    btn_raw = 1'b1;
    for (int g = 1; g <= 4; g++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_dbp.step", step, 1'b0);
    check("rst_dbp.pressed", pressed, 1'b0);
    tick();
    tick();
    check("rst_dbp.hold.pressed", pressed, 1'b0);
    rst_n = 1'b1;
    for (int g = 1; g <= 10; g++) begin
      tick();
      check($sformatf("rst_dbp.g%0d.step", g), step, (g == 7));
      check($sformatf("rst_dbp.g%0d.pressed", g), pressed, (g >= 7));
    end

    // Reset mid-hold: pressed must drop at once, then a fresh press is debounced.
    #2 rst_n = 1'b0;
    #1;
    check("rst_held.step", step, 1'b0);
    check("rst_held.pressed", pressed, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int g = 1; g <= 10; g++) begin
      tick();
      check($sformatf("rst_held.g%0d.step", g), step, (g == 7));
      check($sformatf("rst_held.g%0d.pressed", g), pressed, (g >= 7));
    end
    btn_raw = 1'b0;
    for (int g = 1; g <= 10; g++) begin
      tick();
      check($sformatf("rst_rel.g%0d.step", g), step, 1'b0);
      check($sformatf("rst_rel.g%0d.pressed", g), pressed, (g <= 6));
    end
    $display("[TB] reset sequences done, %0d checks so far, %0d failed", n_tests, n_fail);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
